// File: rtl/game_state_ctrl_pkg.sv
// Shared types and default constants for the game state controller.
package game_pkg;

    // Encoding is visible on game_state and used by the display/sprite logic.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PLAY      = 3'd1,
        RESPAWN   = 3'd2,
        GAME_OVER = 3'd3,
        VICTORY   = 3'd4
    } game_state_e;

    localparam int unsigned MAX_LEVEL_DEF   = 8;
    localparam int unsigned START_LIVES_DEF = 3;

    localparam int unsigned LEVEL_W = 4;
    localparam int unsigned LIVES_W = 2;
    localparam int unsigned STATE_W = 3;

endpackage

// File: rtl/game_state_ctrl_if.sv
// Collision/start inputs and game status outputs of the state controller.
interface game_state_ctrl_if;
    import game_pkg::*;

    logic               start_btn;
    logic               death_collision;
    logic               win_collision;
    logic [LEVEL_W-1:0] current_level;
    logic [LIVES_W-1:0] lives;
    logic               round_reset;
    logic [STATE_W-1:0] game_state;
    logic               level_up;
    logic               life_lost;

    // Driver of the requests, consumer of the status.
    modport master (
        output start_btn, death_collision, win_collision,
        input  current_level, lives, round_reset, game_state, level_up, life_lost
    );

    // The controller itself.
    modport slave (
        input  start_btn, death_collision, win_collision,
        output current_level, lives, round_reset, game_state, level_up, life_lost
    );

endinterface

// File: rtl/game_state_ctrl_rise_detect.sv
// One register stage on a level input plus a rising-edge detector on the registered value.
module rise_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic rise
);

    logic sync_q;
    logic prev_q;

    // Register the input once, then keep the previous registered value for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= din;
            prev_q <= sync_q;
        end
    end

    assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/game_state_ctrl.sv
// Game flow controller: start, play, respawn pause, game over and victory.
module game_state_ctrl
    import game_pkg::*;
#(
    parameter int unsigned MAX_LEVEL      = MAX_LEVEL_DEF,
    parameter int unsigned START_LIVES    = START_LIVES_DEF,
    parameter int unsigned RESPAWN_CYCLES = 25_000_000
) (
    input logic               clk,
    input logic               reset_n,
    game_state_ctrl_if.slave  bus
);

    // Guard keeps the counter at least one bit wide for a single-cycle pause.
    localparam int unsigned CNT_W = (RESPAWN_CYCLES > 1) ? $clog2(RESPAWN_CYCLES) : 1;

    localparam logic [CNT_W-1:0]   CNT_LOAD   = CNT_W'(RESPAWN_CYCLES - 1);
    localparam logic [LEVEL_W-1:0] LEVEL_MAX  = LEVEL_W'(MAX_LEVEL);
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(START_LIVES);

    logic start_ev;
    logic death_ev;
    logic win_ev;

    game_state_e        state_q;
    logic [LEVEL_W-1:0] level_q;
    logic [LIVES_W-1:0] lives_q;
    logic               round_reset_q;
    logic               level_up_q;
    logic               life_lost_q;
    logic [CNT_W-1:0]   cnt_q;

    rise_detect u_start_rise (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (bus.start_btn),
        .rise    (start_ev)
    );

    rise_detect u_death_rise (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (bus.death_collision),
        .rise    (death_ev)
    );

    rise_detect u_win_rise (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (bus.win_collision),
        .rise    (win_ev)
    );

    // Game FSM; every output is registered so pulses line up with the state change.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            level_q       <= '0;
            lives_q       <= LIVES_INIT;
            round_reset_q <= 1'b1;
            level_up_q    <= 1'b0;
            life_lost_q   <= 1'b0;
            cnt_q         <= '0;
        end else begin
            level_up_q  <= 1'b0;
            life_lost_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_ev) begin
                        state_q       <= PLAY;
                        level_q       <= '0;
                        lives_q       <= LIVES_INIT;
                        round_reset_q <= 1'b0;
                    end
                end
                PLAY: begin
                    // Death wins over a simultaneous goal hit; the win is dropped.
                    if (death_ev) begin
                        life_lost_q   <= 1'b1;
                        round_reset_q <= 1'b1;
                        if (lives_q != '0) begin
                            lives_q <= lives_q - LIVES_W'(1);
                        end
                        if (lives_q <= LIVES_W'(1)) begin
                            state_q <= GAME_OVER;
                        end else begin
                            state_q <= RESPAWN;
                            cnt_q   <= CNT_LOAD;
                        end
                    end else if (win_ev) begin
                        level_up_q    <= 1'b1;
                        round_reset_q <= 1'b1;
                        if (level_q >= LEVEL_MAX) begin
                            state_q <= VICTORY;
                        end else begin
                            level_q <= level_q + LEVEL_W'(1);
                            state_q <= RESPAWN;
                            cnt_q   <= CNT_LOAD;
                        end
                    end
                end
                RESPAWN: begin
                    // Counter runs CNT_LOAD..0, one cycle each, then play resumes.
                    if (cnt_q == '0) begin
                        state_q       <= PLAY;
                        round_reset_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                GAME_OVER, VICTORY: begin
                    if (start_ev) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    round_reset_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.game_state    = state_q;
    assign bus.current_level = level_q;
    assign bus.lives         = lives_q;
    assign bus.round_reset   = round_reset_q;
    assign bus.level_up      = level_up_q;
    assign bus.life_lost     = life_lost_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Self-checking bench for game_state_ctrl with a short respawn pause.
module tb_game_state_ctrl;

    localparam int RC    = 4;
    localparam int MAXL  = 8;
    localparam int START = 3;

    localparam int S_IDLE    = 0;
    localparam int S_PLAY    = 1;
    localparam int S_RESPAWN = 2;
    localparam int S_OVER    = 3;
    localparam int S_VICTORY = 4;

    logic clk = 1'b0;
    logic reset_n;

    game_state_ctrl_if bus ();

    game_state_ctrl #(
        .MAX_LEVEL      (MAXL),
        .START_LIVES    (START),
        .RESPAWN_CYCLES (RC)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_total++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s @%0t: actual=%0d required=%0d", name, $time, actual, expected);
    endtask

    // Input values as seen at each rising edge.
    logic s_start, s_death, s_win;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_start <= 1'b0;
            s_death <= 1'b0;
            s_win   <= 1'b0;
        end else begin
            s_start <= bus.start_btn;
            s_death <= bus.death_collision;
            s_win   <= bus.win_collision;
        end
    end

    // Game-rule model: a request is acted on at the edge after the one that first saw it high.
    initial begin
        int m_state, m_level, m_lives, m_rr, m_up, m_lost, m_left;
        logic h1_s, h2_s, h1_d, h2_d, h1_w, h2_w;
        logic ev_s, ev_d, ev_w;
        m_state = S_IDLE; m_level = 0; m_lives = START; m_rr = 1; m_up = 0; m_lost = 0;
        m_left = 0;
        {h1_s, h2_s, h1_d, h2_d, h1_w, h2_w} = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                m_state = S_IDLE; m_level = 0; m_lives = START; m_rr = 1; m_up = 0; m_lost = 0;
                m_left = 0;
                {h1_s, h2_s, h1_d, h2_d, h1_w, h2_w} = '0;
            end else begin
                ev_s = h1_s & ~h2_s;
                ev_d = h1_d & ~h2_d;
                ev_w = h1_w & ~h2_w;
                m_up = 0;
                m_lost = 0;
                case (m_state)
                    S_IDLE: if (ev_s) begin
                        m_state = S_PLAY; m_level = 0; m_lives = START; m_rr = 0;
                    end
                    S_PLAY: if (ev_d) begin
                        m_lost = 1; m_rr = 1;
                        if (m_lives <= 1) m_state = S_OVER;
                        else begin m_state = S_RESPAWN; m_left = RC; end
                        m_lives = (m_lives > 0) ? m_lives - 1 : 0;
                    end else if (ev_w) begin
                        m_up = 1; m_rr = 1;
                        if (m_level == MAXL) m_state = S_VICTORY;
                        else begin m_level++; m_state = S_RESPAWN; m_left = RC; end
                    end
                    S_RESPAWN: if (m_left <= 1) begin
                        m_state = S_PLAY; m_rr = 0;
                    end else m_left--;
                    default: if (ev_s) m_state = S_IDLE;
                endcase
                h2_s = h1_s; h1_s = s_start;
                h2_d = h1_d; h1_d = s_death;
                h2_w = h1_w; h1_w = s_win;
            end
            check("model_state", int'(bus.game_state), m_state);
            check("model_level", int'(bus.current_level), m_level);
            check("model_lives", int'(bus.lives), m_lives);
            check("model_round_reset", int'(bus.round_reset), m_rr);
            check("model_level_up", int'(bus.level_up), m_up);
            check("model_life_lost", int'(bus.life_lost), m_lost);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // One-cycle request pulse on the chosen inputs.
    task automatic pulse(input logic st, input logic dt, input logic wn);
        bus.start_btn       = st;
        bus.death_collision = dt;
        bus.win_collision   = wn;
        tick(1);
        bus.start_btn       = 1'b0;
        bus.death_collision = 1'b0;
        bus.win_collision   = 1'b0;
    endtask

    initial begin
        bus.start_btn       = 1'b0;
        bus.death_collision = 1'b0;
        bus.win_collision   = 1'b0;
        reset_n             = 1'b0;
        tick(1);
        check("rst_state", int'(bus.game_state), S_IDLE);
        check("rst_level", int'(bus.current_level), 0);
        check("rst_lives", int'(bus.lives), 3);
        check("rst_round_reset", int'(bus.round_reset), 1);
        check("rst_pulses", int'(bus.level_up | bus.life_lost), 0);
        @(negedge clk);
        #1 reset_n = 1'b1;
        tick(2);

        // Start
        pulse(1'b1, 1'b0, 1'b0);
        tick(1);
        check("start_state", int'(bus.game_state), S_PLAY);
        check("start_round_reset", int'(bus.round_reset), 0);
        check("start_lives", int'(bus.lives), 3);
        check("start_level", int'(bus.current_level), 0);

        // Climb to level 2
        repeat (2) begin
            pulse(1'b0, 1'b0, 1'b1);
            tick(1 + RC);
        end
        check("lvl2_state", int'(bus.game_state), S_PLAY);
        check("lvl2_level", int'(bus.current_level), 2);

        // Win at level 2, respawn for exactly RC cycles
        pulse(1'b0, 1'b0, 1'b1);
        tick(1);
        check("win_level_up", int'(bus.level_up), 1);
        check("win_level", int'(bus.current_level), 3);
        check("win_state", int'(bus.game_state), S_RESPAWN);
        tick(1);
        check("win_level_up_clear", int'(bus.level_up), 0);
        tick(RC - 2);
        check("win_last_respawn", int'(bus.game_state), S_RESPAWN);
        tick(1);
        check("win_back_play", int'(bus.game_state), S_PLAY);
        check("win_play_round_reset", int'(bus.round_reset), 0);

        // Simultaneous death and win
        bus.death_collision = 1'b1;
        bus.win_collision   = 1'b1;
        tick(1);
        bus.death_collision = 1'b0;
        bus.win_collision   = 1'b0;
        tick(1);
        check("sim_life_lost", int'(bus.life_lost), 1);
        check("sim_level_up", int'(bus.level_up), 0);
        check("sim_level", int'(bus.current_level), 3);
        check("sim_lives", int'(bus.lives), 2);
        tick(RC);

        // Start ignored in PLAY
        pulse(1'b1, 1'b0, 1'b0);
        tick(3);
        check("play_ignore_start", int'(bus.game_state), S_PLAY);

        // Death held high through respawn
        bus.death_collision = 1'b1;
        tick(2);
        check("held_life_lost", int'(bus.life_lost), 1);
        check("held_lives", int'(bus.lives), 1);
        tick(RC);
        check("held_back_play", int'(bus.game_state), S_PLAY);
        tick(3);
        check("held_lives_kept", int'(bus.lives), 1);
        check("held_state_kept", int'(bus.game_state), S_PLAY);
        bus.death_collision = 1'b0;
        tick(2);

        // Win up to the top level, then victory
        repeat (5) begin
            pulse(1'b0, 1'b0, 1'b1);
            tick(1 + RC);
        end
        check("top_level", int'(bus.current_level), 8);
        pulse(1'b0, 1'b0, 1'b1);
        tick(1);
        check("vic_state", int'(bus.game_state), S_VICTORY);
        check("vic_level", int'(bus.current_level), 8);
        check("vic_level_up", int'(bus.level_up), 1);
        check("vic_round_reset", int'(bus.round_reset), 1);
        tick(2);
        check("vic_hold", int'(bus.game_state), S_VICTORY);
        pulse(1'b1, 1'b0, 1'b0);
        tick(1);
        check("vic_to_idle", int'(bus.game_state), S_IDLE);
        pulse(1'b1, 1'b0, 1'b0);
        tick(1);
        check("new_game_state", int'(bus.game_state), S_PLAY);
        check("new_game_lives", int'(bus.lives), 3);
        check("new_game_level", int'(bus.current_level), 0);

        // Three deaths to game over
        pulse(1'b0, 1'b1, 1'b0);
        tick(1);
        check("d1_lives", int'(bus.lives), 2);
        tick(RC);
        pulse(1'b0, 1'b1, 1'b0);
        tick(1);
        check("d2_lives", int'(bus.lives), 1);
        tick(RC);
        pulse(1'b0, 1'b1, 1'b0);
        tick(1);
        check("d3_lives", int'(bus.lives), 0);
        check("d3_state", int'(bus.game_state), S_OVER);
        check("d3_round_reset", int'(bus.round_reset), 1);
        check("d3_life_lost", int'(bus.life_lost), 1);
        pulse(1'b0, 1'b1, 1'b0);
        tick(2);
        check("over_ignore_lives", int'(bus.lives), 0);
        check("over_ignore_state", int'(bus.game_state), S_OVER);
        pulse(1'b1, 1'b0, 1'b0);
        tick(1);
        check("over_to_idle", int'(bus.game_state), S_IDLE);

        // Asynchronous reset during respawn
        pulse(1'b1, 1'b0, 1'b0);
        tick(1);
        pulse(1'b0, 1'b0, 1'b1);
        tick(1);
        check("pre_rst_state", int'(bus.game_state), S_RESPAWN);
        check("pre_rst_level", int'(bus.current_level), 1);
        #1 reset_n = 1'b0;
        #1;
        check("async_rst_state", int'(bus.game_state), S_IDLE);
        check("async_rst_level", int'(bus.current_level), 0);
        check("async_rst_level_up", int'(bus.level_up), 0);
        check("async_rst_round_reset", int'(bus.round_reset), 1);
        tick(2);
        check("rst_hold_state", int'(bus.game_state), S_IDLE);
        @(negedge clk);
        #1 reset_n = 1'b1;
        tick(3);
        check("post_rst_state", int'(bus.game_state), S_IDLE);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
